// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array front-end.
// Holds the default element width, the skew feeder state encoding and a counter-width helper.
package systolic_pkg;

  localparam int DATAWIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } feeder_state_e;

  // Width able to hold n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// One row of the skew network: a DEPTH-stage {valid, data} shift chain that shifts every cycle.
module skew_delay_line #(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  input  logic [DATAWIDTH-1:0] data_i,
  output logic                 valid_o,
  output logic [DATAWIDTH-1:0] data_o
);

  logic [DEPTH-1:0]                vld_q;
  logic [DEPTH-1:0][DATAWIDTH-1:0] dat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= valid_i;
      dat_q[0] <= data_i;
      for (int k = 1; k < DEPTH; k++) begin
        vld_q[k] <= vld_q[k-1];
        dat_q[k] <= dat_q[k-1];
      end
    end
  end

  assign valid_o = vld_q[DEPTH-1];
  assign data_o  = dat_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Diagonal skew feeder: row i sees each accepted vector element i+1 cycles after acceptance.
// Optional per-frame vector counter output enabled by defining SKEW_FEEDER_PERF_EN.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEFAULT,
  parameter int N         = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [N*DATAWIDTH-1:0] s_data,
  input  logic                   s_last,
  output logic [N*DATAWIDTH-1:0] a_out,
  output logic [N-1:0]           a_valid,
  output logic                   busy,
  output logic                   done
`ifdef SKEW_FEEDER_PERF_EN
  ,
  output logic [31:0]            vec_count
`endif
);

  localparam int            CW         = cnt_width(N);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(N - 1);

  feeder_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s_ready_q, s_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          xfer;

  assign xfer = s_valid && s_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, FEED: begin
        if (xfer) begin
          if (s_last) begin
            state_d = DRAIN;
            cnt_d   = DRAIN_LOAD;
          end else begin
            state_d = FEED;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next state, so done lands with the last element on row N-1.
  always_comb begin
    s_ready_d = (state_d != DRAIN);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DRAIN) && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign s_ready = s_ready_q;
  assign busy    = busy_q;
  assign done    = done_q;

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_row
    logic [DATAWIDTH-1:0] row_in;
    assign row_in = xfer ? s_data[gi*DATAWIDTH +: DATAWIDTH] : '0;

    skew_delay_line #(
      .DATAWIDTH(DATAWIDTH),
      .DEPTH    (gi + 1)
    ) u_row (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid_i(xfer),
      .data_i (row_in),
      .valid_o(a_valid[gi]),
      .data_o (a_out[gi*DATAWIDTH +: DATAWIDTH])
    );
  end

`ifdef SKEW_FEEDER_PERF_EN
  logic [31:0] vec_count_q, vec_count_d;

  always_comb begin
    vec_count_d = vec_count_q;
    if (xfer) vec_count_d = (state_q == IDLE) ? 32'd1 : vec_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vec_count_q <= '0;
    else        vec_count_q <= vec_count_d;
  end

  assign vec_count = vec_count_q;
`endif

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream stage of the systolic array. Accepts one N-element activation vector per cycle over a valid/ready stream.
- Emits the elements diagonally skewed: row i is delayed i cycles. Each array row's first PE then receives its in_A and valid_in at the correct wavefront time.
- Tracks frames delimited by a last flag, drains the skew pipeline after the last vector, and pulses done when the final element leaves row N-1.

Parameters:
- DATAWIDTH, 8, bit width of one activation element (matches PE in_A width).
- N, 4, number of array rows / vector elements; legal range 1..64.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  input vector valid.
- s_ready  output  1  feeder can accept a vector this cycle.
- s_data  input  N*DATAWIDTH  input vector; element i at bits [i*DATAWIDTH +: DATAWIDTH].
- s_last  input  1  qualifies the vector as the last of the frame; ignored unless s_valid&&s_ready.
- a_out  output  N*DATAWIDTH  skewed elements; slice i drives row i in_A.
- a_valid  output  N  per-row valid; bit i drives row i valid_in.
- busy  output  1  high when state != IDLE.
- done  output  1  one-cycle pulse when the frame's last element exits row N-1.

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: s_ready=1, a_out=0, a_valid=0, busy=0, done=0, all skew registers and counters 0, state=IDLE.
- Transfer: a transfer occurs when s_valid&&s_ready.
- Skew latency: if a vector is accepted at cycle t, element i appears on a_out slice i with a_valid[i]=1 at cycle t+1+i. All outputs are registered.
- Skew structure: row i is a shift chain of depth i+1 carrying {valid, data}.
- Bubbles: a cycle with no transfer shifts a bubble (valid=0, data=0) into every chain. Bubbles appear skewed exactly like data. a_out slice i is 0 whenever a_valid[i]=0.
- No downstream backpressure: chains shift every cycle.
- States:
  - IDLE: s_ready=1. A transfer with s_last=0 goes to FEED. A transfer with s_last=1 goes to DRAIN.
  - FEED: s_ready=1. A transfer with s_last=1 goes to DRAIN. Otherwise stay, including on bubbles.
  - DRAIN: s_ready=0. A drain counter loads N-1 on entry and decrements each cycle.
  - Drain exit: in the cycle the counter is 0 and the last element is on row N-1, done=1, and the next state is IDLE.
- Drain timing: last vector accepted at t gives DRAIN for cycles t+1..t+N, done=1 at t+N, and s_ready=1 again at t+N+1.
- N=1: DRAIN lasts one cycle; done coincides with a_valid[0] of the last vector.
- s_last with s_valid=0, or while s_ready=0: ignored.
- s_valid during DRAIN: not accepted; upstream must hold it.
- Reset mid-frame: immediately clears all chains, state, counter and done. There is no partial drain.
- The counter width is clog2(N), minimum 1.

Optional Feature:
- Macro: SKEW_FEEDER_PERF_EN.
- When defined:
  - Adds output port vec_count, 32 bits: the number of accepted vectors in the current or most recent frame.
  - Reset value 0. Increments on each transfer and wraps at 2^32.
  - Clears to 0 on the first transfer in IDLE, so that transfer yields 1.
  - Holds its value after done.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package (systolic_pkg): DATAWIDTH default, the feeder state enum typedef (IDLE, FEED, DRAIN), and a clog2-based counter-width helper constant function.
- Sub-module skew_delay_line (parameters DATAWIDTH, DEPTH): a single-row {valid, data} shift chain with async reset. The feeder instantiates it N times via generate, with DEPTH=i+1.

Test Plan:
- Single-vector frame (N=4, DATAWIDTH=8): s_data={8'h04,8'h03,8'h02,8'h01}, s_last=1 at t0 -> a_valid[0]@t0+1=8'h01, [1]@t0+2=8'h02, [2]@t0+3=8'h03, [3]@t0+4=8'h04; s_ready low t0+1..t0+4; done only at t0+4; busy high t0+1..t0+4.
- Back-to-back frame of 3 vectors (row values 10,20,30) with s_last on the third -> row 2 shows 10,20,30 at t0+3..t0+5; done at t0+6; no output gaps.
- Bubble: vector A at t0, s_valid=0 at t0+1, vector B with last at t0+2 -> each row shows A, 0/invalid, B in that order, skewed by row index; done at t0+6.
- Hold during DRAIN: s_valid=1 with new data throughout DRAIN -> not accepted; it is accepted at the first cycle s_ready=1 and appears on row 0 one cycle later.
- Reset mid-frame: assert rst_n=0 while rows 1..3 hold valid data -> all a_valid=0, a_out=0, done=0, busy=0 immediately; s_ready=1 after release.
- SKEW_FEEDER_PERF_EN: two frames of 5 and 2 vectors -> vec_count=5 after the first done, 1 on the first transfer of the second frame, 2 after the second done.
